// File: rtl/jtbubl_arb_pkg.sv
// Shared types and constants for the jtbubl shared-RAM arbiter.
// Used by jtbubl_rr_pick and jtbubl_shared_arb.
package jtbubl_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } arb_state_e;

    typedef logic [1:0] port_idx_t;

    localparam int        NPORTS = 3;
    localparam port_idx_t MAIN   = 2'd0;
    localparam port_idx_t SUB    = 2'd1;
    localparam port_idx_t MCU    = 2'd2;

    // Round-robin successor: main -> sub -> mcu -> main.
    function automatic port_idx_t next_port(input port_idx_t p);
        return (p == MCU) ? MAIN : port_idx_t'(p + 2'd1);
    endfunction

    function automatic port_idx_t onehot_to_idx(input logic [NPORTS-1:0] oh);
        port_idx_t idx;
        idx = MAIN;
        for (int i = 0; i < NPORTS; i++) begin
            if (oh[i]) idx = port_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/jtbubl_rr_pick.sv
// Combinational round-robin picker: the search starts at the port after
// `last` and returns a one-hot grant for the first pending port found.
module jtbubl_rr_pick
    import jtbubl_arb_pkg::*;
(
    input  logic [NPORTS-1:0] pending,
    input  port_idx_t         last,
    output logic [NPORTS-1:0] grant
);

    port_idx_t idx;
    logic      found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = last;
        for (int k = 0; k < NPORTS; k++) begin
            idx = next_port(idx);
            if (!found && pending[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtbubl_shared_arb.sv
// Three-way arbiter for the single-port shared RAM (main, sub, mcu CPUs).
// Define JTBUBL_MCU_ARB_EN to make mcu a third round-robin port.
module jtbubl_shared_arb
    import jtbubl_arb_pkg::*;
#(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk24,
    input  logic          rst_n,

    input  logic          main_cs,
    input  logic          main_we,
    input  logic [AW-1:0] main_addr,
    input  logic [DW-1:0] main_din,
    output logic [DW-1:0] main_dout,
    output logic          main_wait_n,

    input  logic          sub_cs,
    input  logic          sub_we,
    input  logic [AW-1:0] sub_addr,
    input  logic [DW-1:0] sub_din,
    output logic [DW-1:0] sub_dout,
    output logic          sub_wait_n,

    input  logic          mcu_cs,
    input  logic          mcu_we,
    input  logic [AW-1:0] mcu_addr,
    input  logic [DW-1:0] mcu_din,
    output logic [DW-1:0] mcu_dout,
    output logic          mcu_wait_n,

    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q
);

    logic [NPORTS-1:0] cs_vec;
    logic [NPORTS-1:0] we_vec;
    logic [AW-1:0]     addr_arr [NPORTS];
    logic [DW-1:0]     din_arr  [NPORTS];

`ifdef JTBUBL_MCU_ARB_EN
    assign cs_vec[MCU] = mcu_cs;
`else
    // mcu is kept off the rotation; its request line is deliberately dropped.
    logic unused_mcu_cs;
    assign unused_mcu_cs = mcu_cs;
    assign cs_vec[MCU]   = 1'b0;
`endif

    assign cs_vec[MAIN]   = main_cs;
    assign cs_vec[SUB]    = sub_cs;
    assign we_vec         = {mcu_we, sub_we, main_we};
    assign addr_arr[MAIN] = main_addr;
    assign addr_arr[SUB]  = sub_addr;
    assign addr_arr[MCU]  = mcu_addr;
    assign din_arr[MAIN]  = main_din;
    assign din_arr[SUB]   = sub_din;
    assign din_arr[MCU]   = mcu_din;

    arb_state_e        state_q,    state_d;
    port_idx_t         win_q,      win_d;
    port_idx_t         last_q,     last_d;
    logic [NPORTS-1:0] served_q,   served_d;
    logic              req_we_q,   req_we_d;
    logic [AW-1:0]     req_addr_q, req_addr_d;
    logic [DW-1:0]     req_din_q,  req_din_d;
    logic [DW-1:0]     dout_q [NPORTS];
    logic [DW-1:0]     dout_d [NPORTS];

    logic [NPORTS-1:0] pending;
    logic [NPORTS-1:0] grant;
    port_idx_t         grant_idx;

    assign pending   = cs_vec & ~served_q;
    assign grant_idx = onehot_to_idx(grant);

    jtbubl_rr_pick u_pick (
        .pending (pending),
        .last    (last_q),
        .grant   (grant)
    );

    // NOTE: every _d starts as its _q before any branch, so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        last_d     = last_q;
        served_d   = served_q;
        req_we_d   = req_we_q;
        req_addr_d = req_addr_q;
        req_din_d  = req_din_q;
        dout_d     = dout_q;

        // Dropping cs always clears served, even on the winner's CAPTURE cycle.
        for (int i = 0; i < NPORTS; i++) begin
            if (!cs_vec[i]) begin
                served_d[i] = 1'b0;
            end else if (state_q == ST_CAPTURE && win_q == port_idx_t'(i)) begin
                served_d[i] = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (|pending) begin
                    win_d      = grant_idx;
                    last_d     = grant_idx;
                    req_we_d   = we_vec[grant_idx];
                    req_addr_d = addr_arr[grant_idx];
                    req_din_d  = din_arr[grant_idx];
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!req_we_q) dout_d[win_q] = ram_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: rst_n is only sampled here, at the clock edge: reset is synchronous.
    always_ff @(posedge clk24) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            win_q      <= MAIN;
            last_q     <= MCU;
            served_q   <= '0;
            req_we_q   <= 1'b0;
            req_addr_q <= '0;
            req_din_q  <= '0;
            for (int i = 0; i < NPORTS; i++) dout_q[i] <= '0;
        end else begin
            // NOTE: state flops take <= so every flop samples the pre-edge values.
            state_q    <= state_d;
            win_q      <= win_d;
            last_q     <= last_d;
            served_q   <= served_d;
            req_we_q   <= req_we_d;
            req_addr_q <= req_addr_d;
            req_din_q  <= req_din_d;
            for (int i = 0; i < NPORTS; i++) dout_q[i] <= dout_d[i];
        end
    end

    // The request is latched at grant, so a requester may drop cs mid-access.
    assign ram_we   = (state_q == ST_ACCESS) && req_we_q;
    assign ram_addr = req_addr_q;
    assign ram_din  = req_din_q;

    assign main_dout   = dout_q[MAIN];
    assign sub_dout    = dout_q[SUB];
    assign mcu_dout    = dout_q[MCU];
    assign main_wait_n = ~(cs_vec[MAIN] & ~served_q[MAIN]);
    assign sub_wait_n  = ~(cs_vec[SUB]  & ~served_q[SUB]);
    assign mcu_wait_n  = ~(cs_vec[MCU]  & ~served_q[MCU]);

endmodule

// File: tb/tb_jtbubl_shared_arb.sv
// Directed self-checking bench for jtbubl_shared_arb with a one-cycle
// synchronous RAM model; JTBUBL_MCU_ARB_EN selects the three- or two-way test.
module tb_jtbubl_shared_arb;

    localparam int AW = 13;
    localparam int DW = 8;

    logic          clk24 = 1'b0;
    logic          rst_n;
    logic          main_cs, sub_cs, mcu_cs;
    logic          main_we, sub_we, mcu_we;
    logic [AW-1:0] main_addr, sub_addr, mcu_addr;
    logic [DW-1:0] main_din, sub_din, mcu_din;
    logic [DW-1:0] main_dout, sub_dout, mcu_dout;
    logic          main_wait_n, sub_wait_n, mcu_wait_n;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    int checks = 0;
    int errors = 0;
    int wcnt [3];
    int wmax [3];

    always #5 clk24 = ~clk24;

    jtbubl_shared_arb #(.AW(AW), .DW(DW)) dut (
        .clk24(clk24), .rst_n(rst_n),
        .main_cs(main_cs), .main_we(main_we), .main_addr(main_addr), .main_din(main_din),
        .main_dout(main_dout), .main_wait_n(main_wait_n),
        .sub_cs(sub_cs), .sub_we(sub_we), .sub_addr(sub_addr), .sub_din(sub_din),
        .sub_dout(sub_dout), .sub_wait_n(sub_wait_n),
        .mcu_cs(mcu_cs), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_din(mcu_din),
        .mcu_dout(mcu_dout), .mcu_wait_n(mcu_wait_n),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_q(ram_q)
    );

    // RAM model: read-before-write, one cycle latency, plus a preload port.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk24) begin
        ram_q <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_din;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    function automatic int port_of(input logic [AW-1:0] a);
        case (a)
            13'h0100: return 0;
            13'h0200: return 1;
            13'h0300: return 2;
            default:  return 3;
        endcase
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk24);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk24);
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk24);
        rst_n = 1'b0;
        repeat (2) @(negedge clk24);
        rst_n = 1'b1;
    endtask

    task automatic settle();
        main_cs = 1'b0; sub_cs = 1'b0; mcu_cs = 1'b0;
        main_we = 1'b0; sub_we = 1'b0; mcu_we = 1'b0;
        repeat (4) @(negedge clk24);
    endtask

    task automatic main_rw(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output logic [DW-1:0] q, output bit ok);
        @(negedge clk24);
        main_cs = 1'b1; main_we = we; main_addr = a; main_din = d;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk24); #1;
            if (main_wait_n) begin
                ok = 1'b1;
                break;
            end
        end
        q = main_dout;
        main_cs = 1'b0; main_we = 1'b0;
    endtask

    // CPU stand-in: holds cs until served, drops it for one cycle, re-requests.
    task automatic cpu_step(input logic [2:0] en);
        logic [2:0] cs_now, wn, cs_nx;
        cs_now = {mcu_cs, sub_cs, main_cs};
        wn     = {mcu_wait_n, sub_wait_n, main_wait_n};
        cs_nx  = cs_now;
        for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
                if (cs_now[i] && !wn[i]) begin
                    wcnt[i]++;
                    if (wcnt[i] > wmax[i]) wmax[i] = wcnt[i];
                end else if (cs_now[i]) begin
                    cs_nx[i] = 1'b0;
                    wcnt[i]  = 0;
                end else begin
                    cs_nx[i] = 1'b1;
                end
            end
        end
        main_cs = cs_nx[0];
        sub_cs  = cs_nx[1];
        if (en[2]) mcu_cs = cs_nx[2];
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk24); #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
        checks++; if ({main_wait_n, sub_wait_n, mcu_wait_n} !== 3'b111) begin errors++; $display("FAIL reset_wait_n got %b want 111", {main_wait_n, sub_wait_n, mcu_wait_n}); end
        checks++; if ({main_dout, sub_dout, mcu_dout} !== 24'h0) begin errors++; $display("FAIL reset_dout got %h want 000000", {main_dout, sub_dout, mcu_dout}); end
        main_cs = 1'b1; main_we = 1'b1; main_addr = 13'h0777;
        sub_cs  = 1'b1;
        @(negedge clk24); #1;
        checks++; if ({main_wait_n, sub_wait_n, mcu_wait_n} !== 3'b001) begin errors++; $display("FAIL reset_wait_follow_cs got %b want 001", {main_wait_n, sub_wait_n, mcu_wait_n}); end
        @(negedge clk24); #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_hold_ram_we got %b want 0", ram_we); end
        main_cs = 1'b0; main_we = 1'b0; sub_cs = 1'b0;
        preload(13'h0123, 8'hA5);
        rst_n = 1'b1;
        repeat (2) @(negedge clk24);
    endtask

    task automatic test_main_read();
        @(negedge clk24);
        main_cs = 1'b1; main_we = 1'b0; main_addr = 13'h0123; #1;
        checks++; if (main_wait_n !== 1'b0) begin errors++; $display("FAIL read_wait_n0 got %b want 0", main_wait_n); end
        @(negedge clk24); #1;
        checks++; if (ram_we !== 1'b0 || ram_addr !== 13'h0123) begin errors++; $display("FAIL read_access got we=%b addr=%h want we=0 addr=0123", ram_we, ram_addr); end
        checks++; if (main_wait_n !== 1'b0) begin errors++; $display("FAIL read_wait_n1 got %b want 0", main_wait_n); end
        @(negedge clk24); #1;
        checks++; if (main_wait_n !== 1'b0) begin errors++; $display("FAIL read_wait_n2 got %b want 0", main_wait_n); end
        @(negedge clk24); #1;
        checks++; if (main_dout !== 8'hA5) begin errors++; $display("FAIL read_dout got %h want a5", main_dout); end
        checks++; if (main_wait_n !== 1'b1) begin errors++; $display("FAIL read_wait_n3 got %b want 1", main_wait_n); end
        main_cs = 1'b0;
        repeat (3) @(negedge clk24); #1;
        checks++; if (main_dout !== 8'hA5) begin errors++; $display("FAIL read_dout_hold got %h want a5", main_dout); end
    endtask

    task automatic test_two_writes();
        logic [DW-1:0] q;
        bit ok;
        do_reset();
        @(negedge clk24);
        main_cs = 1'b1; main_we = 1'b1; main_addr = 13'h0010; main_din = 8'h11;
        sub_cs  = 1'b1; sub_we  = 1'b1; sub_addr  = 13'h0020; sub_din  = 8'h22;
        @(negedge clk24); #1;
        checks++; if (ram_we !== 1'b1 || ram_addr !== 13'h0010 || ram_din !== 8'h11) begin errors++; $display("FAIL wr_main got we=%b addr=%h din=%h want 1 0010 11", ram_we, ram_addr, ram_din); end
        @(negedge clk24); #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL wr_gap got %b want 0", ram_we); end
        @(negedge clk24); #1;
        checks++; if (main_wait_n !== 1'b1 || sub_wait_n !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL wr_n3 got main_wait_n=%b sub_wait_n=%b we=%b want 1 0 0", main_wait_n, sub_wait_n, ram_we); end
        main_cs = 1'b0; main_we = 1'b0;
        @(negedge clk24); #1;
        checks++; if (ram_we !== 1'b1 || ram_addr !== 13'h0020 || ram_din !== 8'h22) begin errors++; $display("FAIL wr_sub got we=%b addr=%h din=%h want 1 0020 22", ram_we, ram_addr, ram_din); end
        repeat (2) @(negedge clk24); #1;
        checks++; if (sub_wait_n !== 1'b1) begin errors++; $display("FAIL wr_sub_done got %b want 1", sub_wait_n); end
        sub_cs = 1'b0; sub_we = 1'b0;
        settle();
        main_rw(1'b0, 13'h0010, 8'h00, q, ok);
        checks++; if (!ok || q !== 8'h11) begin errors++; $display("FAIL rb_0010 got ok=%b q=%h want 1 11", ok, q); end
        main_rw(1'b0, 13'h0020, 8'h00, q, ok);
        checks++; if (!ok || q !== 8'h22) begin errors++; $display("FAIL rb_0020 got ok=%b q=%h want 1 22", ok, q); end
        settle();
    endtask

    task automatic test_drop_during_access();
        bit ok;
        @(negedge clk24);
        sub_cs = 1'b1; sub_we = 1'b1; sub_addr = 13'h1FFF; sub_din = 8'h5A;
        @(negedge clk24); #1;
        checks++; if (ram_we !== 1'b1 || ram_addr !== 13'h1FFF) begin errors++; $display("FAIL drop_access got we=%b addr=%h want 1 1fff", ram_we, ram_addr); end
        sub_cs = 1'b0; sub_we = 1'b0;
        @(negedge clk24); #1;
        checks++; if (sub_wait_n !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL drop_capture got wait_n=%b we=%b want 1 0", sub_wait_n, ram_we); end
        @(negedge clk24);
        sub_cs = 1'b1; sub_we = 1'b0; #1;
        checks++; if (sub_wait_n !== 1'b0) begin errors++; $display("FAIL drop_served got wait_n=%b want 0", sub_wait_n); end
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk24); #1;
            if (sub_wait_n) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok || sub_dout !== 8'h5A) begin errors++; $display("FAIL drop_readback got ok=%b dout=%h want 1 5a", ok, sub_dout); end
        checks++; if (mem[13'h1FFF] !== 8'h5A) begin errors++; $display("FAIL drop_ram got %h want 5a", mem[13'h1FFF]); end
        settle();
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk24);
        main_cs = 1'b1; main_we = 1'b1; main_addr = 13'h0300; main_din = 8'h77;
        sub_cs  = 1'b1; sub_we  = 1'b1; sub_addr  = 13'h0301; sub_din  = 8'h66;
        @(negedge clk24); #1;
        checks++; if (ram_we !== 1'b1 || ram_addr !== 13'h0300) begin errors++; $display("FAIL rst_mid_access got we=%b addr=%h want 1 0300", ram_we, ram_addr); end
        rst_n = 1'b0;
        @(negedge clk24); #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we got %b want 0", ram_we); end
        checks++; if ({main_wait_n, sub_wait_n, mcu_wait_n} !== 3'b001) begin errors++; $display("FAIL rst_mid_wait got %b want 001", {main_wait_n, sub_wait_n, mcu_wait_n}); end
        @(negedge clk24); #1;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we2 got %b want 0", ram_we); end
        rst_n = 1'b1;
        @(negedge clk24); #1;
        checks++; if (ram_we !== 1'b1 || ram_addr !== 13'h0300) begin errors++; $display("FAIL rst_first_grant got we=%b addr=%h want 1 0300", ram_we, ram_addr); end
        settle();
    endtask

`ifdef JTBUBL_MCU_ARB_EN
    task automatic test_three_way();
        int exp_port;
        int grants;
        do_reset();
        main_we = 1'b1; main_addr = 13'h0100; main_din = 8'h01;
        sub_we  = 1'b1; sub_addr  = 13'h0200; sub_din  = 8'h02;
        mcu_we  = 1'b1; mcu_addr  = 13'h0300; mcu_din  = 8'h03;
        for (int i = 0; i < 3; i++) begin wcnt[i] = 0; wmax[i] = 0; end
        exp_port = 0;
        grants = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk24); #1;
            if (ram_we) begin
                checks++;
                if (port_of(ram_addr) != exp_port) begin errors++; $display("FAIL rr3_order grant %0d got port %0d want %0d", grants, port_of(ram_addr), exp_port); end
                exp_port = (exp_port + 1) % 3;
                grants++;
            end
            cpu_step(3'b111);
        end
        checks++; if (grants < 9) begin errors++; $display("FAIL rr3_grants got %0d want >= 9", grants); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (wmax[i] > 9) begin errors++; $display("FAIL rr3_wait port %0d got %0d want <= 9", i, wmax[i]); end
        end
        settle();
    endtask
`else
    task automatic test_macro_off();
        int exp_port;
        int grants;
        mcu_cs = 1'b1; mcu_we = 1'b1; mcu_addr = 13'h0300; mcu_din = 8'h03;
        do_reset();
        main_we = 1'b1; main_addr = 13'h0100; main_din = 8'h01;
        sub_we  = 1'b1; sub_addr  = 13'h0200; sub_din  = 8'h02;
        for (int i = 0; i < 3; i++) begin wcnt[i] = 0; wmax[i] = 0; end
        exp_port = 0;
        grants = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk24); #1;
            checks++; if (mcu_wait_n !== 1'b1 || mcu_dout !== 8'h00) begin errors++; $display("FAIL off_mcu cycle %0d got wait_n=%b dout=%h want 1 00", c, mcu_wait_n, mcu_dout); end
            if (ram_we) begin
                checks++;
                if (port_of(ram_addr) != exp_port) begin errors++; $display("FAIL off_order grant %0d got port %0d want %0d", grants, port_of(ram_addr), exp_port); end
                exp_port = (exp_port + 1) % 2;
                grants++;
            end
            cpu_step(3'b011);
        end
        checks++; if (grants < 9) begin errors++; $display("FAIL off_grants got %0d want >= 9", grants); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (wmax[i] > 9) begin errors++; $display("FAIL off_wait port %0d got %0d want <= 9", i, wmax[i]); end
        end
        settle();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        main_cs = 1'b0; sub_cs = 1'b0; mcu_cs = 1'b0;
        main_we = 1'b0; sub_we = 1'b0; mcu_we = 1'b0;
        main_addr = '0; sub_addr = '0; mcu_addr = '0;
        main_din = '0; sub_din = '0; mcu_din = '0;
        test_reset();
        test_main_read();
        test_two_writes();
        test_drop_during_access();
        test_reset_mid_access();
`ifdef JTBUBL_MCU_ARB_EN
        test_three_way();
`else
        test_macro_off();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
